// File: rtl/activ_func_arbiter_pkg.sv
// Shared types and constants for the activation-function arbiter and its stage.
package activ_func_arbiter_pkg;

  // Sequencer states; the encoding is visible on debug taps, so keep it fixed.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam int unsigned ActSelW     = 2;
  localparam int unsigned DefaultValW = 16;

  // Activation selects understood by the shared stage.
  localparam logic [ActSelW-1:0] ActRelu    = 2'd0;
  localparam logic [ActSelW-1:0] ActSigmoid = 2'd1;
  localparam logic [ActSelW-1:0] ActTanh    = 2'd2;
  localparam logic [ActSelW-1:0] ActIdent   = 2'd3;

endpackage

// File: rtl/activ_func_arbiter_if.sv
// Request, stage and writeback signals of the activation-function arbiter.
// slave: the arbiter side; master: requesters, stage and writeback sink.
interface activ_func_arbiter_if
  import activ_func_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned VAL_W   = DefaultValW
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*VAL_W-1:0]   req_val;
  logic [NUM_REQ*ActSelW-1:0] req_sel;
  logic [NUM_REQ*VAL_W-1:0]   req_dest;
  logic [NUM_REQ-1:0]         ack;
  logic                       busy;
  logic [VAL_W-1:0]           stg_val;
  logic [ActSelW-1:0]         stg_sel;
  logic [VAL_W-1:0]           stg_dest;
  logic                       stg_we;
  logic                       stg_done;
  logic [VAL_W-1:0]           stg_result;
  logic                       wb_we;
  logic [VAL_W-1:0]           wb_dest;
  logic [VAL_W-1:0]           wb_val;
  logic                       err;

  modport slave (
    input  req, req_val, req_sel, req_dest, stg_done, stg_result,
    output ack, busy, stg_val, stg_sel, stg_dest, stg_we, wb_we, wb_dest, wb_val, err
  );

  modport master (
    output req, req_val, req_sel, req_dest, stg_done, stg_result,
    input  ack, busy, stg_val, stg_sel, stg_dest, stg_we, wb_we, wb_dest, wb_val, err
  );
endinterface

// File: rtl/activ_func_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module activ_func_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last_grant,
  output logic [IdxW-1:0]    winner,
  output logic               any_req
);

  logic [IdxW-1:0] idx;

  // Scan from last_grant+1 upward; the first hit wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IdxW'((32'(last_grant) + i) % NUM_REQ);
      if (!any_req && req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/activ_func_arbiter.sv
// Round-robin arbiter sharing one activation stage among NUM_REQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP. All outputs registered.
// Optional: define ACTARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC cycles
// and raise a sticky err flag.
module activ_func_arbiter
  import activ_func_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned VAL_W       = DefaultValW,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  activ_func_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("activ_func_arbiter: unsupported parameter value");
  end

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [VAL_W-1:0]    sval_q, sval_d;
  logic [ActSelW-1:0]  ssel_q, ssel_d;
  logic [VAL_W-1:0]    sdest_q, sdest_d;
  logic                swe_q, swe_d;
  logic                wbwe_q, wbwe_d;
  logic [VAL_W-1:0]    wbdest_q, wbdest_d;
  logic [VAL_W-1:0]    wbval_q, wbval_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;

  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;

  logic [VAL_W-1:0]    val_arr  [NUM_REQ];
  logic [ActSelW-1:0]  sel_arr  [NUM_REQ];
  logic [VAL_W-1:0]    dest_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign val_arr[i]  = bus.req_val[i*VAL_W +: VAL_W];
    assign sel_arr[i]  = bus.req_sel[i*ActSelW +: ActSelW];
    assign dest_arr[i] = bus.req_dest[i*VAL_W +: VAL_W];
  end

  activ_func_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_pick (
    .req        (bus.req),
    .last_grant (last_q),
    .winner     (pick_idx),
    .any_req    (pick_any)
  );

`ifdef ACTARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    sval_d   = sval_q;
    ssel_d   = ssel_q;
    sdest_d  = sdest_q;
    swe_d    = 1'b0;
    wbwe_d   = 1'b0;
    wbdest_d = wbdest_q;
    wbval_d  = wbval_q;
    ack_d    = '0;
`ifdef ACTARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          sval_d  = val_arr[pick_idx];
          ssel_d  = sel_arr[pick_idx];
          sdest_d = dest_arr[pick_idx];
          swe_d   = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef ACTARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (bus.stg_done) begin
          wbval_d  = bus.stg_result;
          wbdest_d = sdest_q;
          wbwe_d   = 1'b1;
          ack_d    = NUM_REQ'(1) << grant_q;
          state_d  = StResp;
        end
`ifdef ACTARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          // Abort: release the requester without a writeback.
          ack_d   = NUM_REQ'(1) << grant_q;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= IdxW'(NUM_REQ - 1);
      grant_q  <= '0;
      sval_q   <= '0;
      ssel_q   <= '0;
      sdest_q  <= '0;
      swe_q    <= 1'b0;
      wbwe_q   <= 1'b0;
      wbdest_q <= '0;
      wbval_q  <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      sval_q   <= sval_d;
      ssel_q   <= ssel_d;
      sdest_q  <= sdest_d;
      swe_q    <= swe_d;
      wbwe_q   <= wbwe_d;
      wbdest_q <= wbdest_d;
      wbval_q  <= wbval_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

`ifdef ACTARB_TIMEOUT_EN
  // WAIT-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.stg_val  = sval_q;
  assign bus.stg_sel  = ssel_q;
  assign bus.stg_dest = sdest_q;
  assign bus.stg_we   = swe_q;
  assign bus.wb_we    = wbwe_q;
  assign bus.wb_dest  = wbdest_q;
  assign bus.wb_val   = wbval_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_activ_func_arbiter.sv
// Directed bench for activ_func_arbiter (4 requesters, 16-bit values).
module tb_activ_func_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;

  activ_func_arbiter_if #(.NUM_REQ(4), .VAL_W(16)) bus ();

  activ_func_arbiter #(
    .NUM_REQ     (4),
    .VAL_W       (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester i: value 0x1000+i, select i, destination 0x0040+i.
  task automatic load_table();
    for (int i = 0; i < 4; i++) begin
      bus.req_val[i*16 +: 16]  = 16'h1000 + 16'(i);
      bus.req_sel[i*2 +: 2]    = 2'(i);
      bus.req_dest[i*16 +: 16] = 16'h0040 + 16'(i);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req        = '0;
    bus.stg_done   = 1'b0;
    bus.stg_result = '0;
    load_table();
    step();
    step();
    rst = 1'b0;
  endtask

  // Wait for an issue, answer two cycles later, check the completion.
  task automatic serve(input string tag, input logic [15:0] res, input logic [3:0] exp_ack,
                       input logic [15:0] exp_val, input logic [15:0] exp_dest);
    int cyc = 0;
    int we_cnt;
    while (!bus.stg_we && cyc < 20) begin
      step();
      cyc++;
    end
    check_eq({tag, "_issue"}, 32'(bus.stg_we), 32'd1);
    check_eq({tag, "_val"}, 32'(bus.stg_val), 32'(exp_val));
    we_cnt = 1;
    step();
    if (bus.stg_we) we_cnt++;
    step();
    if (bus.stg_we) we_cnt++;
    bus.stg_done   = 1'b1;
    bus.stg_result = res;
    step();
    bus.stg_done = 1'b0;
    check_eq({tag, "_ack"}, 32'(bus.ack), 32'(exp_ack));
    check_eq({tag, "_wbwe"}, 32'(bus.wb_we), 32'd1);
    check_eq({tag, "_wbval"}, 32'(bus.wb_val), 32'(res));
    check_eq({tag, "_wbdest"}, 32'(bus.wb_dest), 32'(exp_dest));
    check_eq({tag, "_wecnt"}, 32'(we_cnt), 32'd1);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    do_reset();
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_we", 32'(bus.stg_we), 32'd0);
    check_eq("rst_ack", 32'(bus.ack), 32'd0);
    check_eq("rst_wbwe", 32'(bus.wb_we), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);

    // Single request from requester 1.
    bus.req_val[16 +: 16]  = 16'h1234;
    bus.req_sel[2 +: 2]    = 2'd2;
    bus.req_dest[16 +: 16] = 16'h0042;
    bus.req                = 4'b0010;
    step();  // cycle 1
    check_eq("one_we", 32'(bus.stg_we), 32'd1);
    check_eq("one_val", 32'(bus.stg_val), 32'h1234);
    check_eq("one_sel", 32'(bus.stg_sel), 32'd2);
    check_eq("one_dest", 32'(bus.stg_dest), 32'h0042);
    check_eq("one_busy", 32'(bus.busy), 32'd1);
    step();  // cycle 2
    check_eq("one_we_off", 32'(bus.stg_we), 32'd0);
    step();  // cycle 3
    bus.stg_done   = 1'b1;
    bus.stg_result = 16'h0777;
    step();  // cycle 4
    bus.stg_done = 1'b0;
    bus.req      = '0;
    check_eq("one_wbwe", 32'(bus.wb_we), 32'd1);
    check_eq("one_wbdest", 32'(bus.wb_dest), 32'h0042);
    check_eq("one_wbval", 32'(bus.wb_val), 32'h0777);
    check_eq("one_ack", 32'(bus.ack), 32'b0010);
    step();  // cycle 5
    check_eq("one_idle", 32'(bus.busy), 32'd0);
    check_eq("one_ack_off", 32'(bus.ack), 32'd0);

    // Fairness: all requesters held high.
    do_reset();
    bus.req = 4'b1111;
    serve("rr0", 16'h0a00, 4'b0001, 16'h1000, 16'h0040);
    serve("rr1", 16'h0a01, 4'b0010, 16'h1001, 16'h0041);
    serve("rr2", 16'h0a02, 4'b0100, 16'h1002, 16'h0042);
    serve("rr3", 16'h0a03, 4'b1000, 16'h1003, 16'h0043);
    serve("rr4", 16'h0a04, 4'b0001, 16'h1000, 16'h0040);

    // Spurious done in IDLE (no request) and in the ISSUE cycle.
    do_reset();
    bus.stg_done = 1'b1;
    step();
    bus.stg_done = 1'b0;
    check_eq("sp_idle_busy", 32'(bus.busy), 32'd0);
    check_eq("sp_idle_wbwe", 32'(bus.wb_we), 32'd0);
    bus.req = 4'b0100;
    step();  // ISSUE
    check_eq("sp_issue_we", 32'(bus.stg_we), 32'd1);
    bus.stg_done   = 1'b1;
    bus.stg_result = 16'h0bad;
    step();  // WAIT
    bus.stg_done = 1'b0;
    check_eq("sp_wait_wbwe", 32'(bus.wb_we), 32'd0);
    check_eq("sp_wait_ack", 32'(bus.ack), 32'd0);
    step();
    check_eq("sp_still_busy", 32'(bus.busy), 32'd1);
    check_eq("sp_still_ack", 32'(bus.ack), 32'd0);
    bus.stg_done   = 1'b1;
    bus.stg_result = 16'h0abc;
    step();  // RESP
    bus.stg_done = 1'b0;
    bus.req      = '0;
    check_eq("sp_ack", 32'(bus.ack), 32'b0100);
    check_eq("sp_wbval", 32'(bus.wb_val), 32'h0abc);

    // Reset in the middle of WAIT, then a late done.
    do_reset();
    bus.req = 4'b1000;
    step();  // ISSUE
    step();  // WAIT
    rst = 1'b1;
    step();
    rst     = 1'b0;
    bus.req = '0;
    check_eq("mr_busy", 32'(bus.busy), 32'd0);
    check_eq("mr_we", 32'(bus.stg_we), 32'd0);
    check_eq("mr_val", 32'(bus.stg_val), 32'd0);
    check_eq("mr_dest", 32'(bus.stg_dest), 32'd0);
    check_eq("mr_wbval", 32'(bus.wb_val), 32'd0);
    check_eq("mr_ack", 32'(bus.ack), 32'd0);
    bus.stg_done   = 1'b1;
    bus.stg_result = 16'h0dea;
    step();
    bus.stg_done = 1'b0;
    check_eq("mr_late_wbwe", 32'(bus.wb_we), 32'd0);
    check_eq("mr_late_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b1001;
    serve("mr_next", 16'h0c00, 4'b0001, 16'h1000, 16'h0040);
    bus.req = '0;

    // Requester 2 drops its request during WAIT.
    do_reset();
    bus.req = 4'b0100;
    step();  // ISSUE
    step();  // WAIT
    bus.req = '0;
    step();
    bus.stg_done   = 1'b1;
    bus.stg_result = 16'h0321;
    step();  // RESP
    bus.stg_done = 1'b0;
    check_eq("drop_ack", 32'(bus.ack), 32'b0100);
    check_eq("drop_wbwe", 32'(bus.wb_we), 32'd1);
    step();
    check_eq("drop_idle", 32'(bus.busy), 32'd0);
    check_eq("drop_ack_off", 32'(bus.ack), 32'd0);

    // No stage answer at all.
    do_reset();
    bus.req = 4'b0001;
    step();  // cycle 1, ISSUE
    step();  // cycle 2, first WAIT cycle
`ifdef ACTARB_TIMEOUT_EN
    for (int i = 3; i <= 17; i++) step();
    check_eq("to_before_ack", 32'(bus.ack), 32'd0);
    check_eq("to_before_busy", 32'(bus.busy), 32'd1);
    step();  // cycle 18
    bus.req = '0;
    check_eq("to_ack", 32'(bus.ack), 32'b0001);
    check_eq("to_wbwe", 32'(bus.wb_we), 32'd0);
    check_eq("to_err", 32'(bus.err), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check_eq("to_err_sticky", 32'(bus.err), 32'd1);
    check_eq("to_idle", 32'(bus.busy), 32'd0);
    do_reset();
    check_eq("to_err_clr", 32'(bus.err), 32'd0);
`else
    for (int i = 0; i < 40; i++) step();
    check_eq("nto_busy", 32'(bus.busy), 32'd1);
    check_eq("nto_err", 32'(bus.err), 32'd0);
    check_eq("nto_ack", 32'(bus.ack), 32'd0);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/activ_func_arbiter.md
Name: activ_func_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one activation-function stage among NUM_REQ neuron requesters.
- Captures a winning request and issues it to the stage as a single write-enable pulse.
- Waits for the stage's result strobe, then writes the result back to the destination and acks the requester.
- Sits between the per-neuron accumulators and the shared activation stage; exactly one transaction is outstanding at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- VAL_W, 16, value and destination width.
- TIMEOUT_CYC, 16, maximum WAIT cycles before abort (used only when the optional feature is compiled in).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_val  in  NUM_REQ*VAL_W  packed input values; requester i occupies slice [i*VAL_W +: VAL_W].
- req_sel  in  NUM_REQ*2  packed activation-function selects.
- req_dest  in  NUM_REQ*VAL_W  packed destination addresses.
- ack  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.
- stg_val  out  VAL_W  value to the stage.
- stg_sel  out  2  select to the stage.
- stg_dest  out  VAL_W  destination to the stage.
- stg_we  out  1  1-cycle issue strobe.
- stg_done  in  1  stage result-valid strobe.
- stg_result  in  VAL_W  stage result.
- wb_we  out  1  1-cycle writeback strobe.
- wb_dest  out  VAL_W  writeback address.
- wb_val  out  VAL_W  writeback data.
- err  out  1  sticky timeout flag (optional feature).

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state = IDLE; last_grant = NUM_REQ-1, so requester 0 has top priority first.
  - All outputs = 0; err = 0.
  - Reset overrides any state, including mid-WAIT; a late stg_done after reset is ignored.
- State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If any req bit is set, the winner g is the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch slice g of req_val, req_sel and req_dest into stg_val, stg_sel and stg_dest; latch g internally; go to ISSUE.
- ISSUE: stg_we = 1 for exactly this cycle; stg_val, stg_sel and stg_dest are stable; next state WAIT.
- WAIT:
  - stg_we = 0; the stg_* data outputs hold their values.
  - On stg_done = 1, capture stg_result into wb_val and stg_dest into wb_dest; go to RESP.
- RESP:
  - wb_we = 1 and ack[g] = 1 for exactly one cycle; last_grant = g; next state IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0 -> stg_we at cycle 1.
  - stg_done at cycle k -> wb_we and ack at cycle k+1.
  - Minimum 4 cycles per transaction; a back-to-back grant can occur in the IDLE cycle right after RESP.
- Requester rules:
  - Hold req and its data until ack.
  - Dropping req after grant does not cancel the transaction; the ack is still pulsed.
  - A req change during ISSUE, WAIT or RESP has no effect until IDLE.
- Boundary conditions:
  - stg_done in IDLE, ISSUE or RESP is ignored.
  - stg_done in the same cycle stg_we is asserted is ignored; only WAIT samples stg_done.
  - All req low in IDLE: remain in IDLE.
  - Single requester continuously high: it is granted every transaction.
  - All requesters high: grants rotate 0,1,2,3,0...
- busy = (state != IDLE).

Optional Feature:
- Macro ACTARB_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter is cleared on entry to WAIT.
  - If the counter reaches TIMEOUT_CYC without stg_done, go to RESP with wb_we = 0, ack[g] = 1, and set err = 1 sticky until rst.
  - last_grant still advances.
- Undefined: no counter; WAIT lasts indefinitely; err is tied to 0.

Decomposition:
- Shared package:
  - State encoding typedef (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
  - ACT_SEL_W = 2 and default VAL_W.
  - Activation-select constants shared with the activation stage.
- One sub-module, rr_pick:
  - Purely combinational round-robin priority picker.
  - Inputs: req vector, last_grant. Outputs: winner index, any_req.

Test Plan:
- Single request: req=4'b0010, req_val[1]=16'h1234, sel=2, dest=16'h0042. Required: stg_we at cycle 1 with stg_val=1234, stg_sel=2, stg_dest=0042. Drive stg_done=1 with stg_result=16'h0777 at cycle 3; required wb_we=1, wb_dest=0042, wb_val=0777 and ack=4'b0010 at cycle 4; busy low at cycle 5.
- Fairness: req=4'b1111 held, stage answers 2 cycles after each stg_we. Required: ack sequence 0001, 0010, 0100, 1000, 0001, and exactly one stg_we per transaction.
- Spurious done: pulse stg_done in IDLE and in the ISSUE cycle. Required: no wb_we and no ack; the transaction completes only on the WAIT-state stg_done.
- Reset mid-WAIT: after issue, assert rst for 1 cycle, then deliver stg_done. Required: all outputs 0, no wb_we, next grant goes to requester 0.
- Timeout (ACTARB_TIMEOUT_EN defined, TIMEOUT_CYC=16): never assert stg_done. Required: ack pulses 16 cycles after entering WAIT, wb_we stays 0, err=1 until rst. With the macro undefined: busy stays high and err stays 0.
- Drop request: req[2] is granted, then deasserted during WAIT. Required: ack[2] still pulses after stg_done, followed by IDLE.
